filter_sample_buffer: RTL

Parametrised multi-channel sample history buffer for the FIR datapath. It replaces the fixed 32-bit single-pointer storage with per-channel circular delay lines. The writer pushes one sample at a time; the tap sequencer reads any past sample by channel and tap offset. Taps older than the samples written since the last clear read as zero, so filters start up cleanly without a memory wipe.

---
 rtl/filter_pkg.sv | 29 ++
 rtl/filter_sample_ram.sv | 34 +++
 rtl/filter_sample_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared defaults and width helpers for the FIR sample history buffer.
package filter_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 512;
    localparam int unsigned CHANNELS_DEF = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Channel index width; a single channel still needs a 1-bit select.
    function automatic int unsigned ch_width(input int unsigned channels);
        return (clog2(channels) > 1) ? clog2(channels) : 1;
    endfunction

    function automatic int unsigned tap_width(input int unsigned depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/filter_sample_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address write and read in one cycle returns the old word.
module filter_sample_ram
    import filter_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned WORDS  = 1024,
    localparam int unsigned ADDR_W = clog2(WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // Storage write and registered read; read sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/filter_sample_buffer.sv
// Multi-channel circular sample history for the FIR tap sequencer.
// Taps older than the samples written since the last clear read as zero.
module filter_sample_buffer
    import filter_pkg::*;
#(
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned DEPTH    = DEPTH_DEF,
    parameter  int unsigned CHANNELS = CHANNELS_DEF,
    localparam int unsigned CH_W     = ch_width(CHANNELS),
    localparam int unsigned TAP_W    = tap_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                clr_en,
    input  logic [CH_W-1:0]     clr_ch,
    input  logic                rd_en,
    input  logic [CH_W-1:0]     rd_ch,
    input  logic [TAP_W-1:0]    rd_tap,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [CHANNELS-1:0] full
);

    localparam int unsigned WORDS    = CHANNELS * DEPTH;
    localparam int unsigned ADDR_W   = clog2(WORDS);
    localparam logic [TAP_W:0] FILL_MAX = (TAP_W + 1)'(DEPTH);

    logic [TAP_W-1:0] head_q [CHANNELS];
    logic [TAP_W-1:0] head_d [CHANNELS];
    logic [TAP_W:0]   fill_q [CHANNELS];
    logic [TAP_W:0]   fill_d [CHANNELS];

    logic              wr_ok, rd_ok, clr_ok;
    logic              wr_drop;
    logic [TAP_W-1:0]  wr_head;
    logic [TAP_W-1:0]  rd_head;
    logic [TAP_W:0]    rd_fill;
    logic [TAP_W-1:0]  rd_slot;
    logic              rd_zero_d;
    logic              rd_zero_q;
    logic              rd_valid_q;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_ok   = 32'(wr_ch)  < CHANNELS;
    assign rd_ok   = 32'(rd_ch)  < CHANNELS;
    assign clr_ok  = 32'(clr_ch) < CHANNELS;
    // A clear on the write's channel drops that write entirely.
    assign wr_drop = clr_en && clr_ok && (clr_ch == wr_ch);

    // Per-channel pointer update: clear beats write, fill saturates at DEPTH.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            head_d[c] = head_q[c];
            fill_d[c] = fill_q[c];
            if (clr_en && clr_ok && (clr_ch == CH_W'(c))) begin
                head_d[c] = '0;
                fill_d[c] = '0;
            end else if (wr_en && wr_ok && (wr_ch == CH_W'(c))) begin
                head_d[c] = head_q[c] + TAP_W'(1);
                if (fill_q[c] != FILL_MAX) begin
                    fill_d[c] = fill_q[c] + (TAP_W + 1)'(1);
                end
            end
        end
    end

    // Pre-update pointer lookup for the write and read channels; an
    // out-of-range read channel selects nothing, so fill 0 forces zero.
    always_comb begin
        wr_head = '0;
        rd_head = '0;
        rd_fill = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (wr_ch == CH_W'(c)) begin
                wr_head = head_q[c];
            end
            if (rd_ch == CH_W'(c)) begin
                rd_head = head_q[c];
                rd_fill = fill_q[c];
            end
        end
    end

    assign rd_slot   = rd_head - TAP_W'(1) - rd_tap;
    assign rd_zero_d = ({1'b0, rd_tap} >= rd_fill);

    assign ram_we    = wr_en && wr_ok && !wr_drop;
    assign ram_re    = rd_en && !rst;
    assign ram_waddr = wr_ok ? ADDR_W'(32'(wr_ch) * DEPTH + 32'(wr_head)) : '0;
    assign ram_raddr = rd_ok ? ADDR_W'(32'(rd_ch) * DEPTH + 32'(rd_slot)) : '0;

    filter_sample_ram #(
        .WIDTH (DATA_W),
        .WORDS (WORDS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Pointer state plus the valid/zero-force bits that travel with the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                head_q[c] <= '0;
                fill_q[c] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                head_q[c] <= head_d[c];
                fill_q[c] <= fill_d[c];
            end
            rd_valid_q <= rd_en;
            // Only updated on a read, so rd_data holds between reads
            // together with the RAM read register.
            if (rd_en) begin
                rd_zero_q <= rd_zero_d;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_zero_q ? '0 : ram_rdata;

    // Full flags straight from the fill registers.
    always_comb begin
        full = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            full[c] = (fill_q[c] == FILL_MAX);
        end
    end

endmodule
